// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line plus parallel receive side of the UART.
// master = receiver (drives RX_*/FRAME_ERR), slave = line driver/consumer.
interface uart_receiver_if;
  logic       UART_RX;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       RX_BUSY;
  logic       FRAME_ERR;

  modport master (
    input  UART_RX,
    output RX_DATA,
    output RX_STATUS,
    output RX_BUSY,
    output FRAME_ERR
  );

  modport slave (
    output UART_RX,
    input  RX_DATA,
    input  RX_STATUS,
    input  RX_BUSY,
    input  FRAME_ERR
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, oversampled, 2-of-3 vote per bit.
// Ports: clk, rst_n (async, active low), bus (uart_receiver_if.master).
module uart_receiver #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input logic             clk,
  input logic             rst_n,
  uart_receiver_if.master bus
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int TW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  // A tick with tcnt = k is the (k+1)-th tick after state entry.
  // Start vote centres one tick ahead so every later window,
  // including the stop bit, sits on or just before the bit centre.
  localparam logic [TW-1:0] START_EVAL = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_EVAL   = TW'(OVERSAMPLE - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_receiver: DIV must be >= 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_receiver: OVERSAMPLE must be even and >= 8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t        state, state_nxt;
  logic          rx_m, rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] eval_pt;
  logic          samp_a, samp_b, eval;
  logic          s_a, s_b, vote;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          shift_en, load, ferr_set;
  logic [7:0]    rx_data;
  logic          rx_status, frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.UART_RX;
      rx_s <= rx_m;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  assign eval_pt = (state == S_START) ? START_EVAL : BIT_EVAL;
  assign samp_a  = tick && (tcnt == eval_pt - TW'(2));
  assign samp_b  = tick && (tcnt == eval_pt - TW'(1));
  assign eval    = tick && (tcnt == eval_pt);
  // Third sample is the live rx_s on the evaluating tick.
  assign vote    = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load      = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick && !rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (eval) state_nxt = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (eval) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (eval) begin
          if (vote) begin
            load      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (tick && rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tcnt    <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_nxt;
      // DATA -> STOP clears on the same tick tcnt would wrap,
      // so the stop bit keeps the data bit cadence.
      if (state_nxt != state) begin
        tcnt    <= '0;
        bit_idx <= '0;
      end else begin
        if (tick)     tcnt    <= tcnt + TW'(1);
        if (shift_en) bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_a   <= 1'b1;
      s_b   <= 1'b1;
      shift <= '0;
    end else begin
      if (samp_a)   s_a   <= rx_s;
      if (samp_b)   s_b   <= rx_s;
      if (shift_en) shift <= {vote, shift[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_status <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_status <= load;
      frame_err <= ferr_set;
      if (load) rx_data <= shift;
    end
  end

  assign bus.RX_DATA   = rx_data;
  assign bus.RX_STATUS = rx_status;
  assign bus.FRAME_ERR = frame_err;
  assign bus.RX_BUSY   = (state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed vector bench for uart_receiver.
// 160 clk per nominal bit (DIV=10, OVERSAMPLE=16).
module tb_uart_receiver;

  localparam int BC = 160;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_receiver_if bus ();

  uart_receiver #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] d;
    int         bc;
    logic [7:0] exp_d;
    int         exp_st;
    int         exp_fe;
  } vec_t;

  vec_t vt[4];

  int total = 0;
  int bad = 0;
  int st_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  int busy_after = 0;
  logic prev_st = 1'b0;
  int busy_drop;

  always @(negedge clk) begin
    if (bus.RX_STATUS) st_cnt <= st_cnt + 1;
    if (bus.FRAME_ERR) fe_cnt <= fe_cnt + 1;
    if (bus.RX_STATUS && bus.FRAME_ERR) both_cnt <= both_cnt + 1;
    if (bus.RX_STATUS && prev_st) wide_cnt <= wide_cnt + 1;
    if (prev_st && bus.RX_BUSY) busy_after <= busy_after + 1;
    prev_st <= bus.RX_STATUS;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input int bc, input logic chk_busy);
    wait_clk(bc / 2);
    if (chk_busy && !bus.RX_BUSY) busy_drop++;
    repeat (bc - bc / 2) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int bc,
                      input logic stop);
    bus.UART_RX = 1'b0;
    bit_time(bc, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bus.UART_RX = d[i];
      bit_time(bc, 1'b1);
    end
    bus.UART_RX = stop;
    bit_time(bc, 1'b0);
  endtask

  int st0, fe0, seen;
  logic [7:0] d81;

  initial begin
    vt[0] = '{8'hFF, 155, 8'hFF, 1, 0};
    vt[1] = '{8'h00, 165, 8'h00, 1, 0};
    vt[2] = '{8'hA5, BC,  8'hA5, 1, 0};
    vt[3] = '{8'h3C, BC,  8'h3C, 1, 0};

    rst_n = 1'b0;
    bus.UART_RX = 1'b1;
    wait_clk(3);
    chk("rst_data", bus.RX_DATA, 8'h00);
    chk("rst_status", bus.RX_STATUS, 1'b0);
    chk("rst_busy", bus.RX_BUSY, 1'b0);
    chk("rst_ferr", bus.FRAME_ERR, 1'b0);

    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      wait_clk(1);
      if (bus.RX_BUSY) seen++;
    end
    chk("idle_busy", seen, 0);
    chk("idle_status", st_cnt, 0);
    chk("idle_ferr", fe_cnt, 0);
    chk("idle_data", bus.RX_DATA, 8'h00);

    for (int i = 0; i < 4; i++) begin
      st0 = st_cnt;
      fe0 = fe_cnt;
      busy_drop = 0;
      send(vt[i].d, vt[i].bc, 1'b1);
      #1;
      chk("vec_data", bus.RX_DATA, vt[i].exp_d);
      chk("vec_status", st_cnt - st0, vt[i].exp_st);
      chk("vec_ferr", fe_cnt - fe0, vt[i].exp_fe);
      chk("vec_busy", busy_drop, 0);
    end
    wait_clk(500);

    st0 = st_cnt;
    fe0 = fe_cnt;
    seen = 0;
    bus.UART_RX = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 40) bus.UART_RX = 1'b1;
      wait_clk(1);
      if (bus.RX_BUSY) seen++;
    end
    chk("glitch_busy", seen > 0, 1'b1);
    chk("glitch_status", st_cnt - st0, 0);
    chk("glitch_ferr", fe_cnt - fe0, 0);
    chk("glitch_data", bus.RX_DATA, 8'h3C);
    chk("glitch_idle", bus.RX_BUSY, 1'b0);

    st0 = st_cnt;
    fe0 = fe_cnt;
    send(8'h55, BC, 1'b0);
    wait_clk(3000);
    chk("ferr_count", fe_cnt - fe0, 1);
    chk("ferr_status", st_cnt - st0, 0);
    chk("ferr_data", bus.RX_DATA, 8'h3C);
    chk("ferr_busy_low", bus.RX_BUSY, 1'b1);
    bus.UART_RX = 1'b1;
    wait_clk(50);
    chk("ferr_busy_rel", bus.RX_BUSY, 1'b0);
    st0 = st_cnt;
    send(8'h0F, BC, 1'b1);
    wait_clk(100);
    chk("after_ferr_data", bus.RX_DATA, 8'h0F);
    chk("after_ferr_st", st_cnt - st0, 1);

    d81 = 8'h81;
    bus.UART_RX = 1'b0;
    wait_clk(BC);
    for (int i = 0; i < 4; i++) begin
      bus.UART_RX = d81[i];
      wait_clk(BC);
    end
    bus.UART_RX = d81[4];
    wait_clk(BC / 2);
    chk("mid_busy", bus.RX_BUSY, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", bus.RX_BUSY, 1'b0);
    chk("async_data", bus.RX_DATA, 8'h00);
    bus.UART_RX = 1'b1;
    wait_clk(20);
    rst_n = 1'b1;
    wait_clk(200);
    st0 = st_cnt;
    fe0 = fe_cnt;
    send(8'h7E, BC, 1'b1);
    wait_clk(500);
    chk("post_rst_st", st_cnt - st0, 1);
    chk("post_rst_fe", fe_cnt - fe0, 0);
    chk("post_rst_data", bus.RX_DATA, 8'h7E);

    chk("strobe_overlap", both_cnt, 0);
    chk("strobe_width", wide_cnt, 0);
    chk("busy_after_st", busy_after, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receiver for 8N1 UART frames: LSB first, one start bit, 8 data bits, one stop bit, no parity. It is the receive-side counterpart of the transmitter stage and shares its port style (UART_* line, RX_* parallel side). It oversamples the asynchronous UART_RX line with a divided-clock tick and majority-votes each bit at its centre. It presents each received byte with a one-cycle strobe.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: ticks per bit. Must be even and ≥ 8.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active low. It clears all state.
- UART_RX  input  1  serial line, asynchronous to clk, idles high.
- RX_DATA  output  8  last good byte. Updated only together with RX_STATUS.
- RX_STATUS  output  1  one-cycle strobe: RX_DATA holds a new byte.
- RX_BUSY  output  1  high from start-bit detection until the FSM returns to IDLE.
- FRAME_ERR  output  1  one-cycle strobe: the stop bit was sampled low.

## Operation
- Input sync: two flops on UART_RX, both reset to 1. All decisions use the second flop (rx_s).
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation.
  - Free-running counter 0..DIV-1, reset 0. The tick pulse is asserted for one clk when the counter equals DIV-1.
  - DIV < 2 is a parameter error.
- Tick counter tcnt: width $clog2(OVERSAMPLE). Cleared on every state entry and incremented on each tick.
- Majority vote: one bit computed from rx_s sampled on the ticks where tcnt = MID-1, MID, MID+1.
  - MID = OVERSAMPLE/2 in START; MID = OVERSAMPLE-1 relative to the bit boundary in DATA and STOP.
  - The vote uses the 2-of-3 majority.
- FSM states:
  - IDLE: RX_BUSY=0. On a tick with rx_s==0, go to START and clear tcnt.
  - START:
    - At tick MID+1, evaluate the vote. Vote 1 is a glitch: go to IDLE with no strobe.
    - Vote 0: reset tcnt to 0 and go to DATA with bit index 0. This re-aligns the tcnt origin to the start-bit centre, so later votes land at bit centres (tcnt OVERSAMPLE-2..0 wrap is avoided by voting at ticks OVERSAMPLE-2, OVERSAMPLE-1, and the wrap tick 0 of the next bit period).
    - Equivalent implementation is allowed if each vote window is centred ±1 tick on the nominal bit centre.
  - DATA:
    - Each bit period is OVERSAMPLE ticks. The vote result is shifted into shift[7] and the register shifts right (LSB first).
    - After bit index 7, go to STOP.
  - STOP:
    - Vote 1: RX_DATA ← shift, RX_STATUS=1 for one clk, go to IDLE.
    - Vote 0: FRAME_ERR=1 for one clk, RX_DATA unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: RX_BUSY stays 1. Go to IDLE on the first tick with rx_s==1. This absorbs break conditions.
- RX_STATUS and FRAME_ERR are never both high in the same cycle.
- RX_DATA holds its value indefinitely. There is no consumer handshake; an unread byte is overwritten by the next good frame.
- Reset mid-frame: all outputs go to reset values immediately and the FSM goes to IDLE. A partial frame is discarded.
- A line already low when reset deasserts is treated as a start edge. It yields either a glitch reject or a FRAME_ERR, never a false RX_STATUS unless a full valid frame follows.

## Timing
- Reset values: RX_DATA=8'h00, RX_STATUS=0, RX_BUSY=0, FRAME_ERR=0, FSM=IDLE, sync flops=1, counters=0.
- Input latency: 2 clk of synchronizer, plus up to DIV clk of tick quantisation, before the start is detected.
- RX_STATUS rises about 9.5 bit periods (±1 tick) after the start falling edge at the pin, plus the sync delay. It is registered.
- RX_BUSY rises 1 clk after the detecting tick. It falls in the same cycle as the RX_STATUS pulse's FSM transition, i.e. RX_BUSY is 0 in the cycle after the strobe.
- Back-to-back frames: a start bit immediately after the stop-bit centre is detected. A stop bit of a half period is tolerated.
- Tolerated baud mismatch: ±3% at OVERSAMPLE=16.

## Test plan
Bench uses CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16 (DIV=10, 160 clk/bit).
- Reset, line idle high for 2000 clk -> all outputs 0, no strobes.
- Frame 0xA5 then frame 0x3C, back-to-back, exact baud -> two RX_STATUS pulses, each 1 clk wide, with RX_DATA=8'hA5 then 8'h3C. FRAME_ERR stays 0. RX_BUSY high throughout each frame.
- Low glitch of 40 clk on an idle line -> RX_BUSY pulses, but no RX_STATUS or FRAME_ERR. RX_DATA unchanged.
- Frame 0x55 with the stop bit driven low, line then held low 3000 clk, then high -> one FRAME_ERR pulse, RX_DATA unchanged. RX_BUSY stays 1 until the line returns high. A following 0x0F frame gives RX_DATA=8'h0F.
- Frame 0xFF at baud +3% (155 clk/bit), then 0x00 at −3% (165 clk/bit) -> both received correctly.
- Assert rst_n low at bit 4 of frame 0x81, release, then send 0x7E -> outputs reset asynchronously. Exactly one strobe follows, with RX_DATA=8'h7E.
